// File: rtl/cmd_word_sink.sv
// ---------------------------------------------------------------------------
// cmd_word_sink
// Receiving end of a controller command bus. Every strobed nonzero command
// word is captured into a small FIFO and then handed to the downstream
// actuator block through a single output register with a valid/ready
// handshake. The block also counts completion words, flags lost words and
// raises an alarm when the bus keeps strobing zero words.
//
// Handshake: a word moves downstream on a posedge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_cmd and
// out_valid do not change. out_valid never depends combinationally on
// out_ready.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         asynchronous, active-high reset
//   cmd_in      command word (y1 = bit 0)
//   cmd_strobe  sample cmd_in on this posedge
//   out_valid   out_cmd holds a word (output FSM in VALID)
//   out_ready   downstream accepts the word
//   out_cmd     word presented downstream, 0 when idle
//   level       FIFO occupancy, output register not included
//   full/empty  level == DEPTH / level == 0
//   overflow    sticky, a nonzero word was dropped
//   done_cnt    saturating count of completion words (y8, y9, y17 all set)
//   idle_alarm  sticky, IDLE_MAX zero words strobed in a row
// ---------------------------------------------------------------------------
module cmd_word_sink #(
  parameter int CMD_W    = 22,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter int IDLE_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_W-1:0]           cmd_in,
  input  logic                       cmd_strobe,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CMD_W-1:0]           out_cmd,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CNT_W-1:0]           done_cnt,
  output logic                       idle_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(IDLE_MAX + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [CMD_W-1:0] out_cmd_q;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]    wr_q, wr_d;
  logic [LW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_w;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             alarm_q, alarm_d;

  logic fifo_empty, fifo_full;
  logic push_req, push, pop, is_done, zero_strobe;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign level_w    = wr_q - rd_q;
  assign fifo_empty = (level_w == '0);
  assign fifo_full  = (level_w == LW'(DEPTH));

  // The output register takes the FIFO head when idle or when the current
  // word is being accepted downstream.
  assign pop         = !fifo_empty && ((state_q == S_IDLE) || out_ready);
  assign push_req    = cmd_strobe && (cmd_in != '0);
  assign push        = push_req && (!fifo_full || pop);
  assign zero_strobe = cmd_strobe && (cmd_in == '0);
  assign is_done     = cmd_in[7] & cmd_in[8] & cmd_in[16];

  always_comb begin
    wr_d       = wr_q;
    rd_d       = rd_q;
    overflow_d = overflow_q | (push_req & ~push);
    done_d     = done_q;
    idle_d     = idle_q;
    if (push) wr_d = wr_q + LW'(1);
    if (pop)  rd_d = rd_q + LW'(1);
    if (push && is_done && (done_q != '1)) done_d = done_q + CNT_W'(1);
    if (zero_strobe) begin
      if (idle_q != IW'(IDLE_MAX)) idle_d = idle_q + IW'(1);
    end else if (cmd_strobe) begin
      // Any nonzero word clears the run, even one that gets dropped.
      idle_d = '0;
    end
    alarm_d = alarm_q | (idle_d == IW'(IDLE_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      done_q     <= '0;
      idle_q     <= '0;
      alarm_q    <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
      alarm_q    <= alarm_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= cmd_in;
  end

  // Output FSM with registered out_valid/out_cmd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            out_cmd_q   <= mem_q[rd_q[AW-1:0]];
            out_valid_q <= 1'b1;
            state_q     <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              out_cmd_q <= mem_q[rd_q[AW-1:0]];
            end else begin
              out_cmd_q   <= '0;
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          out_cmd_q   <= '0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_cmd    = out_cmd_q;
  assign level      = level_w;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign overflow   = overflow_q;
  assign done_cnt   = done_q;
  assign idle_alarm = alarm_q;

endmodule
